ram_fifo_ctrl: RTL and testbench

//  Synchronous FIFO controller that sits directly in front of the 16x8 inferred block RAM.

---
 rtl/ram_fifo_ctrl_pkg.sv | 15 +
 rtl/ram_fifo_ctrl_fifo_ptr.sv | 32 +++
 rtl/ram_fifo_ctrl.sv | 106 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_fifo_ctrl_pkg
// Brief    : Shared sizing for the RAM-backed FIFO and its 16x8 block RAM.
// Revision : 1.0  initial release
// ============================================================================
package ram_fifo_ctrl_pkg;

    localparam int FIFO_DATA_W   = 8;
    localparam int FIFO_ADDR_W   = 4;
    localparam int FIFO_DEPTH    = 2 ** FIFO_ADDR_W;
    localparam int FIFO_AF_LEVEL = 12;

endpackage : ram_fifo_ctrl_pkg
`default_nettype wire

// File: rtl/ram_fifo_ctrl_fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ptr
// Brief    : Wrapping ADDR_W-bit address counter with increment enable.
// Revision : 1.0  initial release
// ============================================================================
module fifo_ptr
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] ptr
);

    logic [ADDR_W-1:0] r_ptr;

    // Natural modulo-2**ADDR_W overflow provides the 15 -> 0 wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (en) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign ptr = r_ptr;

endmodule : fifo_ptr
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_fifo_ctrl
// Brief    : Push/pop FIFO controller driving an external 1-cycle-latency RAM.
// Revision : 1.0  initial release
// ============================================================================
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W   = FIFO_DATA_W,
    parameter int ADDR_W   = FIFO_ADDR_W,
    parameter int AF_LEVEL = FIFO_AF_LEVEL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              ram_w_en,
    output logic [ADDR_W-1:0] ram_w_add,
    output logic [DATA_W-1:0] ram_w_data,
    output logic              ram_r_en,
    output logic [ADDR_W-1:0] ram_r_add,
    input  logic [DATA_W-1:0] ram_r_data
);

    localparam logic [ADDR_W:0] c_DEPTH    = (ADDR_W+1)'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] c_AF_LEVEL = (ADDR_W+1)'(AF_LEVEL);

    logic [ADDR_W:0]   r_count;
    logic              r_pop_valid;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_full;
    logic              w_empty;
    logic              w_push_acc;
    logic              w_pop_acc;
    logic [ADDR_W-1:0] w_wr_ptr;
    logic [ADDR_W-1:0] w_rd_ptr;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    // Acceptance looks only at pre-edge occupancy: no write-through, no bypass.
    assign w_push_acc = push & ~w_full;
    assign w_pop_acc  = pop & ~w_empty;

    fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (w_push_acc),
        .ptr (w_wr_ptr)
    );

    fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (w_pop_acc),
        .ptr (w_rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_pop_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pop_valid <= w_pop_acc;
            r_overflow  <= r_overflow  | (push & w_full);
            r_underflow <= r_underflow | (pop & w_empty);
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign ram_w_en    = w_push_acc;
    assign ram_w_add   = w_wr_ptr;
    assign ram_w_data  = push_data;
    assign ram_r_en    = w_pop_acc;
    assign ram_r_add   = w_rd_ptr;

    // RAM output is already registered, so it is presented unbuffered.
    assign pop_data    = ram_r_data;
    assign pop_valid   = r_pop_valid;

    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (r_count >= c_AF_LEVEL);
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule : ram_fifo_ctrl
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_fifo_ctrl
// Brief    : Scoreboard bench for ram_fifo_ctrl with a behavioural RAM and queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic [7:0] push_data;
    logic       pop;
    logic [7:0] pop_data;
    logic       pop_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic       ram_w_en;
    logic [3:0] ram_w_add;
    logic [7:0] ram_w_data;
    logic       ram_r_en;
    logic [3:0] ram_r_add;
    logic [7:0] ram_r_data;

    always #5 clk = ~clk;

    ram_fifo_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_data   (push_data),
        .pop         (pop),
        .pop_data    (pop_data),
        .pop_valid   (pop_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .ram_w_en    (ram_w_en),
        .ram_w_add   (ram_w_add),
        .ram_w_data  (ram_w_data),
        .ram_r_en    (ram_r_en),
        .ram_r_add   (ram_r_add),
        .ram_r_data  (ram_r_data)
    );

    // 16x8 RAM with registered read, standing in for the parent's block RAM.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ram_w_en) mem[ram_w_add] <= ram_w_data;
        if (ram_r_en) ram_r_data <= mem[ram_r_add];
    end

    // Reference model: contents as a queue, addresses as running totals mod 16.
    logic [7:0] model_q [$];
    logic [7:0] sb_q [$];
    int         n_push_acc;
    int         n_pop_acc;
    bit         m_ovf;
    bit         m_unf;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: every accepted pop must surface exactly one cycle later.
    always @(posedge clk) begin
        #1;
        if (pop_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pop_valid", 1, 0);
            end else begin
                logic [7:0] e;
                e = sb_q.pop_front();
                check("pop_data", int'(pop_data), int'(e));
                if (e == 8'hA5) check("a5_seen", 1, 0);
            end
        end else if (sb_q.size() != 0) begin
            void'(sb_q.pop_front());
            check("missing_pop_valid", int'(pop_valid), 1);
        end
    end

    task automatic check_state();
        int c;
        c = model_q.size();
        check("count",       int'(count),       c);
        check("full",        int'(full),        int'(c == 16));
        check("empty",       int'(empty),       int'(c == 0));
        check("almost_full", int'(almost_full), int'(c >= 12));
        check("overflow",    int'(overflow),    int'(m_ovf));
        check("underflow",   int'(underflow),   int'(m_unf));
    endtask

    task automatic step(input bit p, input logic [7:0] d, input bit q);
        bit pa;
        bit qa;
        @(negedge clk);
        rst = 1'b0; push = p; push_data = d; pop = q;
        #1;
        check_state();
        pa = p && (model_q.size() < 16);
        qa = q && (model_q.size() > 0);
        check("ram_w_en", int'(ram_w_en), int'(pa));
        check("ram_r_en", int'(ram_r_en), int'(qa));
        if (pa) begin
            check("ram_w_add",  int'(ram_w_add),  n_push_acc % 16);
            check("ram_w_data", int'(ram_w_data), int'(d));
        end
        if (qa) check("ram_r_add", int'(ram_r_add), n_pop_acc % 16);
        @(posedge clk);
        if (qa) begin
            sb_q.push_back(model_q.pop_front());
            n_pop_acc++;
        end
        if (pa) begin
            model_q.push_back(d);
            n_push_acc++;
        end
        if (p && !pa) m_ovf = 1'b1;
        if (q && !qa) m_unf = 1'b1;
    endtask

    task automatic do_reset(input bit p, input bit q);
        @(negedge clk);
        rst = 1'b1; push = p; push_data = 8'hEE; pop = q;
        @(posedge clk);
        model_q.delete();
        n_push_acc = 0; n_pop_acc = 0;
        m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; push = 1'b0; push_data = '0; pop = 1'b0;
        do_reset(0, 0);
        do_reset(0, 0);
        // Fill with 0x00..0x0F, then drain.
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
        step(0, 8'h00, 0);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1);
        step(0, 8'h00, 0);
        // Push while full with a simultaneous pop must be dropped.
        for (int i = 0; i < 16; i++) step(1, 8'(8'h20 + i), 0);
        step(1, 8'hA5, 1);
        step(0, 8'h00, 0);
        // Drain, then pop on empty with a simultaneous push.
        for (int i = 0; i < 15; i++) step(0, 8'h00, 1);
        step(1, 8'h3C, 1);
        step(0, 8'h00, 0);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0);
        // Wrap-around through address 15 -> 0.
        for (int i = 0; i < 10; i++) step(1, 8'(8'h40 + i), 0);
        for (int i = 0; i < 10; i++) step(0, 8'h00, 1);
        for (int i = 0; i < 10; i++) step(1, 8'(8'h50 + i), 0);
        for (int i = 0; i < 10; i++) step(0, 8'h00, 1);
        for (int i = 0; i < 5; i++)  step(1, 8'(8'h60 + i), 0);
        for (int i = 0; i < 8; i++)  step(1, 8'(8'h70 + i), 1);
        step(0, 8'h00, 0);
        // Reset mid-operation with a pop accepted in the reset cycle.
        do_reset(0, 0);
        for (int i = 0; i < 8; i++) step(1, 8'(8'h80 + i), 0);
        step(0, 8'h00, 1);
        do_reset(1, 1);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        // Randomized traffic with varying push/pop bias.
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i / 100) % 3;
            step(($urandom_range(0, 3) < 1 + bias), 8'($urandom), ($urandom_range(0, 3) < 3 - bias));
        end
        for (int i = 0; i < 20; i++) step(0, 8'h00, 1);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ram_fifo_ctrl
`default_nettype wire
